// File: rtl/alu_seq_param.sv
// Sequential parameterised ALU: operands latched on start, registered result/flags,
// accumulator feedback, and an iterative shift-add multiplier taking WIDTH cycles.
module alu_seq_param #(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [SHW-1:0]   i_shamt,
  input  logic             i_use_acc,
  input  logic             i_show_flags,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic [3:0]       o_flags,
  output logic [WIDTH-1:0] o_out
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL} state_t;
  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_MUL
  } op_t;

  typedef struct packed {
    op_t              op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SHW-1:0]   shamt;
  } req_t;

  state_t             r_state, w_state_nx;
  req_t               r_req;
  logic [2*WIDTH-1:0] r_prod;
  logic [SHW-1:0]     r_cnt;
  logic               r_mfin;
  logic [WIDTH-1:0]   r_result, r_acc;
  logic [3:0]         r_flags;
  logic               r_done;

  logic [WIDTH:0]     w_sum, w_shl, w_shr, w_madd;
  logic [WIDTH-1:0]   w_dif, w_res;
  logic [2*WIDTH-1:0] w_prod_nx;
  logic               w_c, w_v, w_oor, w_fin, w_amsb, w_bmsb;

  assign w_amsb = r_req.a[WIDTH-1];
  assign w_bmsb = r_req.b[WIDTH-1];
  assign w_sum  = {1'b0, r_req.a} + {1'b0, r_req.b};
  assign w_dif  = r_req.a - r_req.b;
  // One spare bit on each shift catches the bit shifted out, which becomes C.
  assign w_shl  = {1'b0, r_req.a} << r_req.shamt;
  assign w_shr  = {r_req.a, 1'b0} >> r_req.shamt;
  assign w_oor  = (32'(r_req.shamt) >= WIDTH);

  // Right-shifting multiplier: add A into the upper half when the low bit of B is set.
  assign w_madd    = {1'b0, r_prod[2*WIDTH-1:WIDTH]} +
                     {1'b0, (r_prod[0] ? r_req.a : {WIDTH{1'b0}})};
  assign w_prod_nx = {w_madd, r_prod[WIDTH-1:1]};

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (r_req.op)
      OP_ADD: begin
        {w_c, w_res} = w_sum;
        w_v = (w_amsb == w_bmsb) && (w_sum[WIDTH-1] != w_amsb);
      end
      OP_SUB: begin
        w_res = w_dif;
        w_c   = (r_req.a < r_req.b);
        w_v   = (w_amsb != w_bmsb) && (w_dif[WIDTH-1] != w_amsb);
      end
      OP_AND: w_res = r_req.a & r_req.b;
      OP_OR:  w_res = r_req.a | r_req.b;
      OP_XOR: w_res = r_req.a ^ r_req.b;
      OP_SHL: if (!w_oor) begin
        w_res = w_shl[WIDTH-1:0];
        w_c   = w_shl[WIDTH];
      end
      OP_SHR: if (!w_oor) begin
        w_res = w_shr[WIDTH:1];
        w_c   = w_shr[0];
      end
      OP_MUL: begin
        w_res = r_prod[WIDTH-1:0];
        w_c   = |r_prod[2*WIDTH-1:WIDTH];
        w_v   = w_c;
      end
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: if (i_start) w_state_nx = (op_t'(i_op) == OP_MUL) ? S_MUL : S_EXEC;
      S_EXEC: w_state_nx = S_IDLE;
      S_MUL:  if (r_mfin) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // MUL spends WIDTH cycles iterating, then one more cycle registering the product.
  assign w_fin = (r_state == S_EXEC) || ((r_state == S_MUL) && r_mfin);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_req    <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_mfin   <= 1'b0;
      r_result <= '0;
      r_flags  <= '0;
      r_acc    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_fin;
      if (r_state == S_IDLE && i_start) begin
        r_req.op    <= op_t'(i_op);
        r_req.a     <= i_use_acc ? r_acc : i_a;
        r_req.b     <= i_b;
        r_req.shamt <= i_shamt;
        r_prod      <= {{WIDTH{1'b0}}, i_b};
        r_cnt       <= SHW'(WIDTH - 1);
        r_mfin      <= 1'b0;
      end
      if (r_state == S_MUL && !r_mfin) begin
        r_prod <= w_prod_nx;
        if (r_cnt == '0) r_mfin <= 1'b1;
        else             r_cnt  <= r_cnt - 1'b1;
      end
      if (w_fin) begin
        r_result <= w_res;
        r_flags  <= {w_c, w_v, w_res[WIDTH-1], (w_res == '0)};
        r_acc    <= w_res;
      end
    end
  end

  assign o_busy   = (r_state != S_IDLE);
  assign o_done   = r_done;
  assign o_result = r_result;
  assign o_flags  = r_flags;
  assign o_out    = i_show_flags ? WIDTH'(r_flags) : r_result;

endmodule

// File: tb/tb_alu_seq_param.sv
// Self-checking bench for alu_seq_param: directed table, mid-MUL reset, random ops
// against an arithmetic reference model, and a WIDTH=16 instance.
module tb_alu_seq_param;

  logic       clk, rst;
  logic       start, use_acc, show_flags, busy, done;
  logic [2:0] op, shamt;
  logic [7:0] a, b, result, out;
  logic [3:0] flags;

  logic        s_start, s_use_acc, s_show, s_busy, s_done;
  logic [2:0]  s_op;
  logic [3:0]  s_shamt, s_flags;
  logic [15:0] s_a, s_b, s_result, s_out;

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] model_acc;

  alu_seq_param #(.WIDTH(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_op(op), .i_a(a), .i_b(b),
    .i_shamt(shamt), .i_use_acc(use_acc), .i_show_flags(show_flags),
    .o_busy(busy), .o_done(done), .o_result(result), .o_flags(flags), .o_out(out));

  alu_seq_param #(.WIDTH(16)) dut16 (
    .i_clk(clk), .i_rst(rst), .i_start(s_start), .i_op(s_op), .i_a(s_a), .i_b(s_b),
    .i_shamt(s_shamt), .i_use_acc(s_use_acc), .i_show_flags(s_show),
    .o_busy(s_busy), .o_done(s_done), .o_result(s_result), .o_flags(s_flags), .o_out(s_out));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned/signed interpretations.
  function automatic void model(input int w, input int mop, input longint ma, input longint mb,
                                input int sh, output longint r, output logic [3:0] fl);
    longint m, half, sa, sb, t;
    logic c, v;
    m = 64'sd1 <<< w; half = m / 2;
    sa = (ma >= half) ? ma - m : ma;
    sb = (mb >= half) ? mb - m : mb;
    c = 1'b0; v = 1'b0; r = 0;
    case (mop)
      0: begin t = ma + mb; r = t % m; c = (t >= m); t = sa + sb; v = (t >= half) || (t < -half); end
      1: begin r = (ma - mb + m) % m; c = (ma < mb); t = sa - sb; v = (t >= half) || (t < -half); end
      2: r = ma & mb;
      3: r = ma | mb;
      4: r = ma ^ mb;
      5: if (sh < w) begin r = (ma * (64'sd1 <<< sh)) % m; c = (sh != 0) && (((ma >>> (w - sh)) & 1) == 1); end
      6: if (sh < w) begin r = ma >>> sh; c = (sh != 0) && (((ma >>> (sh - 1)) & 1) == 1); end
      default: begin t = ma * mb; r = t % m; c = (t >= m); v = c; end
    endcase
    fl = {c, v, (r >= half), (r == 0)};
  endfunction

  // Called at a negedge; returns at the negedge where done is seen (so the next call is back-to-back).
  task automatic run(input logic [2:0] top, input logic [7:0] ta, input logic [7:0] tb,
                     input logic [2:0] tsh, input logic tua, input bit poke, output int lat);
    op = top; a = ta; b = tb; shamt = tsh; use_acc = tua; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = ~ta; b = ~tb; op = ~top;
    chk("busy after start", busy, 1'b1);
    lat = 0;
    while (!done && lat < 40) begin
      if (poke && lat == 2) begin start = 1'b1; op = 3'd0; a = 8'h01; b = 8'h01; end
      else start = 1'b0;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk("busy low at done", busy, 1'b0);
  endtask

  typedef struct {
    logic [2:0] op;
    logic [7:0] a, b;
    logic [2:0] sh;
    logic       ua, poke;
    logic [7:0] er;
    logic [3:0] ef;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int lat;
    longint mr;
    logic [3:0] mf;
    logic [7:0] ea;
    bit saw;

    tbl[0]  = '{3'd0, 8'h7F, 8'h01, 3'd0, 1'b0, 1'b0, 8'h80, 4'b0110};
    tbl[1]  = '{3'd1, 8'h00, 8'h01, 3'd0, 1'b0, 1'b0, 8'hFF, 4'b1010};
    tbl[2]  = '{3'd5, 8'h81, 8'h00, 3'd1, 1'b0, 1'b0, 8'h02, 4'b1000};
    tbl[3]  = '{3'd6, 8'h01, 8'h00, 3'd1, 1'b0, 1'b0, 8'h00, 4'b1001};
    tbl[4]  = '{3'd7, 8'h10, 8'h10, 3'd0, 1'b0, 1'b1, 8'h00, 4'b1101};
    tbl[5]  = '{3'd7, 8'h0F, 8'h0F, 3'd0, 1'b0, 1'b0, 8'hE1, 4'b0010};
    tbl[6]  = '{3'd0, 8'h05, 8'h03, 3'd0, 1'b0, 1'b0, 8'h08, 4'b0000};
    tbl[7]  = '{3'd0, 8'hAA, 8'h02, 3'd0, 1'b1, 1'b0, 8'h0A, 4'b0000};
    tbl[8]  = '{3'd2, 8'hF0, 8'h3C, 3'd0, 1'b0, 1'b0, 8'h30, 4'b0000};
    tbl[9]  = '{3'd3, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 8'h00, 4'b0001};
    tbl[10] = '{3'd4, 8'hFF, 8'h0F, 3'd0, 1'b0, 1'b0, 8'hF0, 4'b0010};
    tbl[11] = '{3'd5, 8'h80, 8'h00, 3'd0, 1'b0, 1'b0, 8'h80, 4'b0010};
    tbl[12] = '{3'd6, 8'h80, 8'h00, 3'd7, 1'b0, 1'b0, 8'h01, 4'b0000};
    tbl[13] = '{3'd1, 8'h80, 8'h01, 3'd0, 1'b0, 1'b0, 8'h7F, 4'b0100};
    tbl[14] = '{3'd5, 8'h01, 8'h00, 3'd7, 1'b0, 1'b0, 8'h80, 4'b0010};

    start = 0; op = 0; a = 0; b = 0; shamt = 0; use_acc = 0; show_flags = 0;
    s_start = 0; s_op = 0; s_a = 0; s_b = 0; s_shamt = 0; s_use_acc = 0; s_show = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset result", result, 8'h00);
    chk("reset flags", flags, 4'h0);
    chk("reset out", out, 8'h00);
    show_flags = 1'b1; #1;
    chk("reset out flags", out, 8'h00);
    show_flags = 1'b0;

    for (int i = 0; i < 15; i++) begin
      run(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].sh, tbl[i].ua, tbl[i].poke, lat);
      chk($sformatf("vec%0d latency", i), lat, (tbl[i].op == 3'd7) ? 9 : 1);
      chk($sformatf("vec%0d result", i), result, tbl[i].er);
      chk($sformatf("vec%0d flags", i), flags, tbl[i].ef);
      chk($sformatf("vec%0d out", i), out, tbl[i].er);
      show_flags = 1'b1; #1;
      chk($sformatf("vec%0d out flags", i), out, {4'h0, tbl[i].ef});
      show_flags = 1'b0;
    end

    // Reset during MUL: abort, no done, outputs and accumulator cleared.
    @(negedge clk);
    op = 3'd7; a = 8'h10; b = 8'h10; use_acc = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst busy", busy, 1'b0);
    chk("midrst done", done, 1'b0);
    chk("midrst result", result, 8'h00);
    chk("midrst flags", flags, 4'h0);
    saw = 1'b0;
    repeat (15) begin @(negedge clk); if (done) saw = 1'b1; end
    chk("midrst no late done", saw, 1'b0);
    run(3'd0, 8'h77, 8'h02, 3'd0, 1'b1, 1'b0, lat);
    chk("midrst acc cleared", result, 8'h02);
    model_acc = 8'h02;

    for (int i = 0; i < 40; i++) begin
      logic [2:0] rop, rsh;
      logic [7:0] ra, rb;
      logic rua;
      rop = 3'($urandom_range(0, 7)); ra = 8'($urandom); rb = 8'($urandom);
      rsh = 3'($urandom_range(0, 7)); rua = 1'($urandom);
      ea = rua ? model_acc : ra;
      model(8, int'(rop), longint'(ea), longint'(rb), int'(rsh), mr, mf);
      run(rop, ra, rb, rsh, rua, 1'b0, lat);
      chk($sformatf("rnd%0d op%0d latency", i, rop), lat, (rop == 3'd7) ? 9 : 1);
      chk($sformatf("rnd%0d op%0d result", i, rop), result, mr[7:0]);
      chk($sformatf("rnd%0d op%0d flags", i, rop), flags, mf);
      model_acc = mr[7:0];
    end

    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) begin s_op = 3'd7; s_a = 16'h0100; s_b = 16'h0100; s_shamt = 4'd0; end
      else begin
        s_op = 3'($urandom_range(0, 7)); s_a = 16'($urandom); s_b = 16'($urandom);
        s_shamt = 4'($urandom);
      end
      model(16, int'(s_op), longint'(s_a), longint'(s_b), int'(s_shamt), mr, mf);
      s_start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      s_start = 1'b0;
      lat = 0;
      while (!s_done && lat < 60) begin @(negedge clk); lat++; end
      chk($sformatf("w16 %0d latency", k), lat, (s_op == 3'd7) ? 17 : 1);
      chk($sformatf("w16 %0d result", k), s_result, mr[15:0]);
      chk($sformatf("w16 %0d flags", k), s_flags, mf);
      s_show = 1'b1; #1;
      chk($sformatf("w16 %0d out flags", k), s_out, {12'h000, mf});
      if (k == 0) chk("w16 mul out", s_out, 16'h000D);
      s_show = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
